// File: rtl/rpi_cmd_slave.sv
// Raspberry Pi parallel-bus responder: register map, 16+16 command assembly
// into cpucmd_fifo, strobes synchronised into clk.
module rpi_cmd_slave #(
  parameter int RPI_DATA_WIDTH = 18,
  parameter int RPI_ADDR_WIDTH = 6,
  parameter int FT_DATA_WIDTH  = 32,
  parameter int SYNC_STAGES    = 2,
  parameter logic [RPI_DATA_WIDTH-1:0] ID_VALUE = 18'h25D12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [RPI_ADDR_WIDTH-1:0] rpi_a,
  input  logic [RPI_DATA_WIDTH-1:0] rpi_d_i,
  output logic [RPI_DATA_WIDTH-1:0] rpi_d_o,
  output logic                      rpi_d_oe,
  input  logic                      rpi_we,
  input  logic                      rpi_oe,
  output logic [FT_DATA_WIDTH-1:0]  cmd_fifo_data,
  output logic                      cmd_fifo_we,
  input  logic                      cmd_fifo_full,
  input  logic [7:0]                status_i,
  output logic [7:0]                ctrl_o
);

  localparam int HALF = FT_DATA_WIDTH / 2;
  localparam int CW   = $clog2(SYNC_STAGES + 1);

  localparam logic [RPI_ADDR_WIDTH-1:0] ADDR_CTRL   = RPI_ADDR_WIDTH'(0);
  localparam logic [RPI_ADDR_WIDTH-1:0] ADDR_STATUS = RPI_ADDR_WIDTH'(1);
  localparam logic [RPI_ADDR_WIDTH-1:0] ADDR_LO     = RPI_ADDR_WIDTH'(2);
  localparam logic [RPI_ADDR_WIDTH-1:0] ADDR_HI     = RPI_ADDR_WIDTH'(3);
  localparam logic [RPI_ADDR_WIDTH-1:0] ADDR_ID     = RPI_ADDR_WIDTH'(4);

  // state    | meaning
  // FLUSH    | after reset: wait for the synchroniser to hold real samples and we idle
  // IDLE     | no write in progress
  // CAPTURE  | we low, sampling a/d every cycle
  // COMMIT   | one cycle applying the last captured write
  // ABORT    | we/oe conflict seen; wait for we to return high, no commit
  typedef enum logic [2:0] {
    ST_FLUSH, ST_IDLE, ST_CAPTURE, ST_COMMIT, ST_ABORT
  } state_t;

  state_t                    state_q;
  logic [CW-1:0]             flush_q;
  logic [SYNC_STAGES-1:0]    we_sync_q;
  logic [SYNC_STAGES-1:0]    oe_sync_q;
  logic                      we_hist_q;
  logic                      oe_hist_q;
  logic [RPI_ADDR_WIDTH-1:0] addr_q;
  logic [RPI_DATA_WIDTH-1:0] wdata_q;
  logic [7:0]                ctrl_q;
  logic [HALF-1:0]           lo_q;
  logic                      lo_valid_q;
  logic                      err_q;
  logic                      ovf_q;
  logic [FT_DATA_WIDTH-1:0]  fifo_data_q;
  logic                      fifo_we_q;
  logic [RPI_DATA_WIDTH-1:0] dout_q;
  logic                      doe_q;

  logic                      we_s;
  logic                      oe_s;
  logic                      we_rise;
  logic                      oe_fall;
  logic [RPI_DATA_WIDTH-1:0] status_word;
  logic [RPI_DATA_WIDTH-1:0] rd_data;

  assign we_s    = we_sync_q[SYNC_STAGES-1];
  assign oe_s    = oe_sync_q[SYNC_STAGES-1];
  assign we_rise = we_s & ~we_hist_q;
  assign oe_fall = ~oe_s & oe_hist_q;

  always_comb begin
    status_word     = '0;
    status_word[7:0] = status_i;
    status_word[8]  = cmd_fifo_full;
    status_word[9]  = lo_valid_q;
    status_word[16] = ovf_q;
    status_word[17] = err_q;
  end

  always_comb begin
    rd_data = '0;
    case (rpi_a)
      ADDR_CTRL:   rd_data[7:0] = ctrl_q;
      ADDR_STATUS: rd_data = status_word;
      ADDR_ID:     rd_data = ID_VALUE;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FLUSH;
      flush_q     <= CW'(SYNC_STAGES);
      we_sync_q   <= '1;
      oe_sync_q   <= '1;
      we_hist_q   <= 1'b1;
      oe_hist_q   <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      lo_q        <= '0;
      lo_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      fifo_data_q <= '0;
      fifo_we_q   <= 1'b0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
    end else begin
      we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], rpi_we};
      oe_sync_q <= {oe_sync_q[SYNC_STAGES-2:0], rpi_oe};
      we_hist_q <= we_s;
      oe_hist_q <= oe_s;
      fifo_we_q <= 1'b0;

      // Read data is frozen at the oe fall; a simultaneous write strobe suppresses the drive.
      if (oe_fall && we_s) begin
        dout_q <= rd_data;
        doe_q  <= 1'b1;
      end else if (oe_s || !we_s) begin
        doe_q  <= 1'b0;
      end

      case (state_q)
        ST_FLUSH: begin
          if (flush_q != '0)
            flush_q <= flush_q - CW'(1);
          else if (we_s)
            state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!we_s && !oe_s) begin
            err_q   <= 1'b1;
            state_q <= ST_ABORT;
          end else if (!we_s) begin
            addr_q  <= rpi_a;
            wdata_q <= rpi_d_i;
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!we_s && !oe_s) begin
            err_q   <= 1'b1;
            state_q <= ST_ABORT;
          end else if (!we_s) begin
            addr_q  <= rpi_a;
            wdata_q <= rpi_d_i;
          end else if (we_rise) begin
            state_q <= ST_COMMIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
          case (addr_q)
            ADDR_CTRL: ctrl_q <= wdata_q[7:0];
            ADDR_STATUS: begin
              if (wdata_q[17]) err_q <= 1'b0;
              if (wdata_q[16]) ovf_q <= 1'b0;
            end
            ADDR_LO: begin
              lo_q       <= wdata_q[HALF-1:0];
              lo_valid_q <= 1'b1;
            end
            ADDR_HI: begin
              lo_valid_q <= 1'b0;
              if (lo_valid_q && !cmd_fifo_full) begin
                fifo_data_q <= {wdata_q[HALF-1:0], lo_q};
                fifo_we_q   <= 1'b1;
              end else if (!lo_valid_q) begin
                err_q <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        ST_ABORT: begin
          if (we_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rpi_d_o       = dout_q;
  assign rpi_d_oe      = doe_q;
  assign cmd_fifo_data = fifo_data_q;
  assign cmd_fifo_we   = fifo_we_q;
  assign ctrl_o        = ctrl_q;

endmodule
